edge_event_arbiter: RTL and testbench

Multi-channel edge-event controller that shares one downstream event consumer between N edge-detector channels. Each channel samples an asynchronous-free, clock-domain-local input, detects a configurable falling or rising edge, and latches a pending event. A round-robin arbiter presents one pending event at a time on a valid/ready port and records per-channel overflow. It sits between the raw level inputs and any interrupt or event-logging logic.

---
 rtl/edge_event_arbiter.sv | 121 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detectors feeding a round-robin
// arbiter that offers one pending event at a time on a valid/ready port.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    edge_sel,
    input  logic [N-1:0]    enable,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic [N-1:0]    ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state, state_n;
    logic [N-1:0]    a_q;
    logic            armed;
    logic [N-1:0]    det;
    logic [N-1:0]    acc_vec;
    logic            accept;
    logic [ID_W-1:0] rr_ptr, rr_n;
    logic [ID_W-1:0] id_n;
    logic [ID_W-1:0] sel;
    logic            found;

    // Input history; reloads during reset so released levels never look like edges.
    always_ff @(posedge clk) begin
        a_q <= a;
    end

    // Detection stays masked until the first edge after reset release.
    always_ff @(posedge clk) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    assign accept    = (state == OFFER) && evt_ready;
    assign evt_valid = (state == OFFER);

    // Edge detection and one-hot accept vector for the offered channel.
    always_comb begin
        det     = '0;
        acc_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (armed && enable[i]) begin
                det[i] = edge_sel[i] ? (a[i] & ~a_q[i]) : (~a[i] & a_q[i]);
            end
            acc_vec[i] = accept && (evt_id == ID_W'(i));
        end
    end

    // A new edge on the channel being accepted keeps its pending bit;
    // a detection lost to an already pending event is sticky in overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= (pending & ~acc_vec) | det;
            overflow <= (overflow & ~ovf_clr) | (det & pending & ~acc_vec);
        end
    end

    // Round-robin search starting at rr_ptr and wrapping at N-1.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr_ptr) + k) % N;
            if (!found && pending[j]) begin
                found = 1'b1;
                sel   = ID_W'(j);
            end
        end
    end

    // Arbiter next-state: pick a winner in IDLE, hold it in OFFER until accepted.
    always_comb begin
        state_n = state;
        id_n    = evt_id;
        rr_n    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    id_n    = sel;
                    state_n = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    rr_n    = (evt_id == ID_W'(N - 1)) ? '0 : evt_id + 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            evt_id <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            evt_id <= id_n;
            rr_ptr <= rr_n;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed stimulus with an id scoreboard; a
// negedge monitor pops expected ids on every accepted handshake.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    a, edge_sel, enable, ovf_clr;
    logic            evt_valid, evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [N-1:0]    pending, overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    int acc_cyc[$];

    edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .a(a), .edge_sel(edge_sel),
        .enable(enable), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .pending(pending), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Cycle counter for handshake spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every handshake must match the next expected id.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            total = total + 1;
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_event got id=%0d expected none", evt_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(evt_id) != e) begin
                    bad = bad + 1;
                    $display("FAIL event_id got=%0d expected=%0d", evt_id, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; a = 4'hF; edge_sel = 4'h0; enable = 4'hF;
        evt_ready = 1'b0; ovf_clr = 4'h0;
        step(2);
        reset = 1'b0;
        step(3);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_id", 32'(evt_id), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        // single falling edge on channel 0
        a[0] = 1'b0; exp_q.push_back(0);
        step(1);
        chk("t1_pending", 32'(pending), 32'h1);
        chk("t1_valid_lat", 32'(evt_valid), 32'h0);
        step(1);
        chk("t1_valid", 32'(evt_valid), 32'h1);
        chk("t1_id", 32'(evt_id), 32'h0);
        evt_ready = 1'b1;
        step(1);
        chk("t1_pending_clr", 32'(pending), 32'h0);
        chk("t1_valid_clr", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0; a = 4'hF;
        step(1);

        // three simultaneous edges, ready held high
        acc_cyc.delete();
        a[3:1] = 3'b000; evt_ready = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        step(8);
        chk("t2_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("t2_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
            chk("t2_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
        end
        evt_ready = 1'b0; a = 4'hF;
        step(1);

        // round robin after id 3: 0 then 3
        a[0] = 1'b0; a[3] = 1'b0; evt_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(3);
        step(6);
        a = 4'hF;
        step(1);
        a[1] = 1'b0; exp_q.push_back(1);
        step(4);
        a = 4'hF;
        step(1);
        // after id 1: 2 then 0
        a[0] = 1'b0; a[2] = 1'b0;
        exp_q.push_back(2); exp_q.push_back(0);
        step(6);
        a = 4'hF; evt_ready = 1'b0;
        step(2);
        chk("t3_pending", 32'(pending), 32'h0);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // overflow on rising channel 2
        edge_sel[2] = 1'b1;
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; exp_q.push_back(2); step(1);
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; step(1);
        chk("t4_ovf", 32'(overflow), 32'h4);
        chk("t4_pending", 32'(pending), 32'h4);
        chk("t4_valid", 32'(evt_valid), 32'h1);
        chk("t4_id", 32'(evt_id), 32'h2);
        evt_ready = 1'b1; step(1);
        evt_ready = 1'b0;
        chk("t4_single", 32'(pending), 32'h0);
        chk("t4_ovf_held", 32'(overflow), 32'h4);
        ovf_clr = 4'h4; step(1);
        ovf_clr = 4'h0;
        chk("t4_ovf_clr", 32'(overflow), 32'h0);
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; exp_q.push_back(2); step(1);
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; ovf_clr = 4'h4; step(1);
        ovf_clr = 4'h0;
        chk("t4_set_wins", 32'(overflow), 32'h4);
        evt_ready = 1'b1; step(1);
        evt_ready = 1'b0;
        ovf_clr = 4'h4; step(1);
        ovf_clr = 4'h0;
        chk("t4_ovf_clr2", 32'(overflow), 32'h0);

        // accept coinciding with new edge on the offered channel
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; exp_q.push_back(2); step(2);
        a[2] = 1'b0; step(1);
        a[2] = 1'b1; evt_ready = 1'b1; exp_q.push_back(2); step(1);
        chk("t5_pending", 32'(pending), 32'h4);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_valid", 32'(evt_valid), 32'h0);
        step(3);
        evt_ready = 1'b0;
        chk("t5_done", 32'(pending), 32'h0);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);
        edge_sel = 4'h0;
        step(1);

        // disabled channel ignores its edge
        enable[1] = 1'b0; a[1] = 1'b0; step(2);
        chk("t6_disabled", 32'(pending), 32'h0);
        chk("t6_no_valid", 32'(evt_valid), 32'h0);
        a[1] = 1'b1; enable = 4'hF; step(1);

        // reset during OFFER discards the event
        a[0] = 1'b0; step(2);
        chk("t6_offer", 32'(evt_valid), 32'h1);
        reset = 1'b1; step(1);
        chk("t6_rst_valid", 32'(evt_valid), 32'h0);
        chk("t6_rst_pending", 32'(pending), 32'h0);
        chk("t6_rst_id", 32'(evt_id), 32'h0);
        reset = 1'b0; step(4);
        chk("t6_post_pending", 32'(pending), 32'h0);
        chk("t6_post_valid", 32'(evt_valid), 32'h0);
        a[0] = 1'b1; step(3);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
